// File: rtl/sha256_block_feeder.sv
// SHA-256 message feeder: fetches NUM_OF_WORDS words, appends padding and length, emits 512-bit blocks.
// Optional FEEDER_BYTE_SWAP_EN byte-reverses every memory word before placement.
module sha256_block_feeder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic [7:0]   blk_index,
    output logic         busy,
    output logic         done
);
    localparam int          NB  = (32 * NUM_OF_WORDS + 65 + 511) / 512;
    localparam logic [63:0] LEN = 64'(32 * NUM_OF_WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  blk_j;
    logic [4:0]  cnt;
    logic [15:0] base;
    logic [3:0]  slot;
    logic [15:0] g;
    logic [31:0] mem_word;
    logic [31:0] slot_word;
    logic        last_blk;

    assign last_blk = (blk_j == 8'(NB - 1));

    // Cycle c writes slot c-1; at c=16 the low nibble wraps to slot 15.
    assign slot = cnt[3:0] - 4'd1;
    assign g    = {4'b0, blk_j, 4'b0} + {12'b0, slot};

`ifdef FEEDER_BYTE_SWAP_EN
    assign mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                       mem_read_data[23:16], mem_read_data[31:24]};
`else
    assign mem_word = mem_read_data;
`endif

    always_comb begin
        slot_word = 32'h0;
        if (last_blk && slot == 4'd14)
            slot_word = LEN[63:32];
        else if (last_blk && slot == 4'd15)
            slot_word = LEN[31:0];
        else if (g < 16'(NUM_OF_WORDS))
            slot_word = mem_word;
        else if (g == 16'(NUM_OF_WORDS))
            slot_word = 32'h8000_0000;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (cnt == 5'd16) state_nxt = PRESENT;
            PRESENT: if (blk_ready) state_nxt = last_blk ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            blk_j    <= 8'd0;
            cnt      <= 5'd0;
            base     <= 16'h0;
            mem_addr <= 16'h0;
            blk_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    base     <= message_addr;
                    mem_addr <= message_addr;
                    blk_j    <= 8'd0;
                    cnt      <= 5'd0;
                end
                FETCH: begin
                    cnt <= (cnt == 5'd16) ? 5'd0 : cnt + 5'd1;
                    // mem_addr stays on the last word address once slot 15 is requested
                    if (cnt < 5'd15)
                        mem_addr <= mem_addr + 16'd1;
                    if (cnt != 5'd0)
                        blk_data[{~slot, 5'b0} +: 32] <= slot_word;
                end
                PRESENT: if (blk_ready && !last_blk) begin
                    blk_j    <= blk_j + 8'd1;
                    mem_addr <= base + {4'b0, blk_j + 8'd1, 4'b0};
                end
                default: ;
            endcase
        end
    end

    assign blk_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign blk_last  = busy && last_blk;
    assign blk_index = blk_j;

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Scoreboard bench for sha256_block_feeder: three lockstepped instances (N=20,13,14) vs a padded-message model.
module tb_sha256_block_feeder;
    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [7:0]   idx;
    } blk_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  message_addr;
    logic         blk_ready;
    logic [15:0]  mem_addr_w  [3];
    logic [31:0]  rdata_w     [3];
    logic [511:0] blk_data_w  [3];
    logic [7:0]   blk_index_w [3];
    logic [2:0]   blk_valid_w, blk_last_w, busy_w, done_w;

    logic [31:0] mem [0:65535];
    blk_t        exp_q [3][$];
    int          exp_nb [3];
    bit          prev_v [3];
    int          cyc = 0;
    int          cs = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          full_ready = 1'b0;
    logic [15:0] cur_base = 16'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nw(int i);
        return (i == 0) ? 20 : (i == 1) ? 13 : 14;
    endfunction

    function automatic logic [31:0] mw(logic [31:0] w);
`ifdef FEEDER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(string nm, int i, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[inst %0d] @cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    // Reference: build the padded message as a word list, then slice into 16-word blocks.
    task automatic push_expect(int i, int n, logic [15:0] base);
        logic [31:0] w[$];
        blk_t        b;
        int          nb;
        for (int k = 0; k < n; k++) w.push_back(mw(mem[16'(base + 16'(k))]));
        w.push_back(32'h8000_0000);
        while (w.size() % 16 != 14) w.push_back(32'h0);
        w.push_back(32'h0);
        w.push_back(32'(32 * n));
        nb = w.size() / 16;
        exp_nb[i] = nb;
        for (int j = 0; j < nb; j++) begin
            b.data = '0;
            for (int k = 0; k < 16; k++) b.data[511 - 32 * k -: 32] = w[16 * j + k];
            b.last = (j == nb - 1);
            b.idx  = 8'(j);
            exp_q[i].push_back(b);
        end
    endtask

    task automatic mon(int i);
        blk_t e;
        if (reset) begin
            prev_v[i] = 1'b0;
        end else begin
            if (blk_valid_w[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_blk[inst %0d] @cyc %0d: got index %0d expected none", i, cyc, blk_index_w[i]);
                end else begin
                    e = exp_q[i][0];
                    chk("blk_data",  i, blk_data_w[i], e.data);
                    chk("blk_last",  i, 512'(blk_last_w[i]), 512'(e.last));
                    chk("blk_index", i, 512'(blk_index_w[i]), 512'(e.idx));
                    chk("mem_addr_hold", i, 512'(mem_addr_w[i]),
                        512'(16'(cur_base + 16'(16 * int'(e.idx)) + 16'd15)));
                    if (!prev_v[i] && e.idx == 8'd0)
                        chk("valid_rise", i, 512'(cyc - cs), 512'(17));
                    if (blk_ready) void'(exp_q[i].pop_front());
                end
            end
            if (done_w[i]) begin
                chk("done_q_empty", i, 512'(exp_q[i].size()), 512'(0));
                if (full_ready) chk("done_cycle", i, 512'(cyc - cs), 512'(18 * exp_nb[i]));
            end
            prev_v[i] = blk_valid_w[i];
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        sha256_block_feeder #(.NUM_OF_WORDS((gi == 0) ? 20 : (gi == 1) ? 13 : 14)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start),
            .message_addr (message_addr),
            .mem_addr     (mem_addr_w[gi]),
            .mem_read_data(rdata_w[gi]),
            .blk_valid    (blk_valid_w[gi]),
            .blk_ready    (blk_ready),
            .blk_data     (blk_data_w[gi]),
            .blk_last     (blk_last_w[gi]),
            .blk_index    (blk_index_w[gi]),
            .busy         (busy_w[gi]),
            .done         (done_w[gi])
        );
        always @(posedge clk) rdata_w[gi] <= mem[mem_addr_w[gi]];
        always @(negedge clk) mon(gi);
    end

    task automatic chk_rst();
        for (int i = 0; i < 3; i++) begin
            chk("rst_mem_addr",  i, 512'(mem_addr_w[i]), 512'(0));
            chk("rst_blk_data",  i, blk_data_w[i], 512'(0));
            chk("rst_blk_valid", i, 512'(blk_valid_w[i]), 512'(0));
            chk("rst_blk_last",  i, 512'(blk_last_w[i]), 512'(0));
            chk("rst_blk_index", i, 512'(blk_index_w[i]), 512'(0));
            chk("rst_busy",      i, 512'(busy_w[i]), 512'(0));
            chk("rst_done",      i, 512'(done_w[i]), 512'(0));
        end
    endtask

    // Drive start for one edge (edge S); returns in cycle S+1.
    task automatic issue(logic [15:0] base);
        cur_base     = base;
        message_addr = base;
        start        = 1'b1;
        for (int i = 0; i < 3; i++) push_expect(i, nw(i), base);
        @(posedge clk); #1;
        cs    = cyc;
        start = 1'b0;
        for (int i = 0; i < 3; i++) chk("first_addr", i, 512'(mem_addr_w[i]), 512'(base));
    endtask

    // mode 0: ready held high, 1: random ready, 2: 10-cycle backpressure with a stray start
    task automatic run(logic [15:0] base, int mode);
        int hold = 0;
        bit seen = 1'b0;
        full_ready = (mode == 0);
        blk_ready  = (mode == 0);
        issue(base);
        for (int t = 0; t < 400 && busy_w != 3'b0; t++) begin
            if (mode == 1) blk_ready = 1'($urandom_range(0, 1));
            if (mode == 2 && (seen || blk_valid_w[0])) begin
                seen = 1'b1;
                hold++;
                start        = (hold == 3);
                message_addr = (hold == 3) ? ~base : base;
                if (hold > 10) blk_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        message_addr = base;
        if (busy_w != 3'b0) begin
            n_cmp++; n_err++;
            $display("FAIL run_timeout: got busy %b expected 000", busy_w);
        end
    endtask

    task automatic fill(logic [15:0] base, bit seq);
        for (int k = 0; k < 20; k++) mem[16'(base + 16'(k))] = seq ? 32'(k) : $urandom;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; message_addr = 16'h0; blk_ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst();
        @(posedge clk); #1;
        reset = 1'b0;

        fill(16'h0000, 1'b1);
        run(16'h0000, 0);

        fill(16'h0100, 1'b0);
        mem[16'h0100] = 32'h1122_3344;
        run(16'h0100, 0);

        fill(16'h0200, 1'b0);
        run(16'h0200, 2);

        // Abort at FETCH c=7, then the same message must reproduce the golden blocks.
        fill(16'h0000, 1'b1);
        full_ready = 1'b1;
        blk_ready  = 1'b1;
        issue(16'h0000);
        repeat (7) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("addr_c7", i, 512'(mem_addr_w[i]), 512'(7));
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_rst();
        @(posedge clk); #1;
        run(16'h0000, 0);

        for (int r = 0; r < 8; r++) begin
            logic [15:0] b;
            b = (r == 3) ? 16'hFFF6 : 16'($urandom);
            fill(b, 1'b0);
            run(b, (r % 3 == 0) ? 0 : 1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", 0, 512'(busy_w), 512'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
